zero_run_event_monitor: RTL and testbench
=========================================

# zero_run_event_monitor

Downstream consumer of the zero-run detector flag `Y`. It detects each rising edge of the flag and counts those edges in a saturating counter. It raises a level interrupt when a programmable threshold is reached and holds it until software acknowledges. It sits between the serial zero-run detector and the control/status register bank.

## Interface
Parameters:
- `W`, default 8: event-counter and threshold width.
- `TSW`, default 16: timestamp width. Used only when `TIMESTAMP_EN` is defined.

Ports:
- `CLK` input, 1 bit: the single clock. All logic is on its rising edge.
- `CLR` input, 1 bit: reset, synchronous and active-high.
- `Y_IN` input, 1 bit: detector flag, synchronous to `CLK`.
- `EN` input, 1 bit: counting enable.
- `CNT_CLR` input, 1 bit: synchronous clear of `CNT` and `OVF`.
- `THRESH` input, `W` bits: interrupt threshold. A value of 0 disables the interrupt.
- `IRQ_ACK` input, 1 bit: interrupt acknowledge, single-cycle pulse.
- `CNT` output, `W` bits: event count.
- `OVF` output, 1 bit: sticky saturation flag.
- `IRQ` output, 1 bit: level interrupt.
- `LAST_TS` output, `TSW` bits: timestamp of the last event. Present only with `TIMESTAMP_EN`.

## Operation
- Edge detect:
  - `y_q` registers `Y_IN` every cycle, in all states.
  - `evt = Y_IN & ~y_q & EN`.
  - Enabling while `Y_IN` is already high produces no event.
  - An alternating flag (detector toggling between S3 and S4 on a continued zero run) produces one event per rising edge.
- Counter:
  - On `evt`, `CNT` increments and saturates at 2^W−1.
  - An `evt` while `CNT` is saturated sets `OVF`.
  - `OVF` clears only on `CLR` or `CNT_CLR`.
- Threshold hit: `hit = evt & (THRESH != 0) & (CNT + 1 == THRESH)`, evaluated with `CNT` before saturation.
- FSM states: IDLE, RUN, ALERT.
  - IDLE: go to RUN when `EN`=1.
  - RUN:
    - `hit` goes to ALERT and sets `IRQ`.
    - Otherwise, `EN`=0 goes to IDLE.
  - ALERT:
    - `IRQ`=1.
    - Events are still counted while `EN`=1.
    - `IRQ_ACK` clears `IRQ`, then goes to RUN if `EN`=1, else IDLE.
    - `EN` deassertion does not leave ALERT.
  - Illegal state encoding goes to IDLE.
- Simultaneous events:
  - `CNT_CLR` with `evt`: clear wins. `CNT`=0 and the event is dropped.
  - `CNT_CLR` with `hit`: the hit is dropped.
  - `IRQ_ACK` with `hit` in ALERT: the hit wins. Stay in ALERT with `IRQ`=1.
  - `IRQ_ACK` outside ALERT: ignored.
  - `CLR` overrides everything.
- `THRESH` changes take effect on the next `evt`. There is no retroactive hit if `CNT` is already at or above the new threshold.

## Timing
- Reset values: state IDLE, `y_q`=0, `CNT`=0, `OVF`=0, `IRQ`=0, `LAST_TS`=0.
- Latency:
  - `Y_IN` rising, sampled at edge k: `CNT`, `OVF`, `IRQ` and `LAST_TS` update at edge k.
  - `IRQ_ACK` sampled at edge k: `IRQ`=0 after edge k.
- Minimum event spacing is 2 cycles, because a rising edge needs one low sample.
- `CLR` mid-operation, including in ALERT: every register returns to its reset value at that edge. The pending interrupt is lost.

## Configuration
- Macro: `TIMESTAMP_EN`.
- Defined:
  - A free-running `TSW`-bit cycle counter is built. It is reset by `CLR` and wraps from 2^TSW−1 to 0.
  - On `evt`, `LAST_TS` captures the counter value at that edge, i.e. the count of edges since `CLR`, modulo 2^TSW.
  - `CNT_CLR` does not affect the timestamp.
- Not defined: no timestamp counter, no `LAST_TS` port, and all other behaviour is identical.

## Structure
- Package `zero_run_mon_pkg` holds:
  - the `mon_state_t` enum (IDLE=2'b00, RUN=2'b01, ALERT=2'b10);
  - default constants `MON_W_DEF`=8 and `MON_TSW_DEF`=16.
- One sub-module, `rise_edge_det`: a 1-bit register plus `d & ~q`, instantiated for `Y_IN`.

## Test plan
- **Basic count:** `CLR` for 2 cycles, `EN`=1, then three isolated 1-cycle `Y_IN` pulses. Expect `CNT`=3, `IRQ`=0, `OVF`=0.
- **Interrupt and acknowledge:** `THRESH`=2, two pulses. Expect `IRQ`=1 at the edge sampling the second pulse. `IRQ_ACK` pulse gives `IRQ`=0 the next edge and state RUN.
- **Saturation:** `W`=4, 16 pulses. Expect `CNT`=15 and `OVF`=1. `CNT_CLR` gives `CNT`=0 and `OVF`=0.
- **Simultaneous events:**
  - `CNT_CLR` together with a pulse gives `CNT`=0.
  - In ALERT with `THRESH` set so that one more event yields `CNT`+1==`THRESH` (e.g. `THRESH`=1, `CNT`=0 after `CNT_CLR` — repeat the hit), `IRQ_ACK` together with that hit leaves `IRQ`=1.
- **Enable gating:** hold `Y_IN` high, raise `EN`. Expect no count. `Y_IN` pulsing 0101 for 8 cycles gives `CNT`=4.
- **Timestamp (`TIMESTAMP_EN`):** a pulse sampled 10 edges after `CLR` release gives `LAST_TS`=10. `CLR` during ALERT gives all outputs 0 the next edge.

Source files
------------

// File: rtl/zero_run_mon_pkg.sv
// rtl/zero_run_mon_pkg.sv - shared types and defaults for the zero-run event monitor
package zero_run_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    ALERT = 2'b10
  } mon_state_t;

  localparam int MON_W_DEF   = 8;
  localparam int MON_TSW_DEF = 16;

endpackage

// File: rtl/rise_edge_det.sv
// rtl/rise_edge_det.sv - one-cycle pulse on each low-to-high transition of d
module rise_edge_det (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (clr) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/zero_run_event_monitor.sv
// rtl/zero_run_event_monitor.sv - counts detector flag rising edges, threshold IRQ; TIMESTAMP_EN adds LAST_TS
module zero_run_event_monitor
  import zero_run_mon_pkg::*;
#(
  parameter int W = MON_W_DEF
`ifdef TIMESTAMP_EN
  , parameter int TSW = MON_TSW_DEF
`endif
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         Y_IN,
  input  logic         EN,
  input  logic         CNT_CLR,
  input  logic [W-1:0] THRESH,
  input  logic         IRQ_ACK,
  output logic [W-1:0] CNT,
  output logic         OVF,
  output logic         IRQ
`ifdef TIMESTAMP_EN
  , output logic [TSW-1:0] LAST_TS
`endif
);

  logic       rise;
  logic       evt;
  logic       sat;
  logic       hit;
  mon_state_t state;
  mon_state_t state_nxt;

  rise_edge_det u_y_edge (
    .clk  (CLK),
    .clr  (CLR),
    .d    (Y_IN),
    .rise (rise)
  );

  assign evt = rise & EN;
  assign sat = &CNT;
  // Compare one bit wider so a saturated count never aliases to a small threshold.
  assign hit = evt & (THRESH != '0) & ~CNT_CLR &
               (({1'b0, CNT} + (W+1)'(1)) == {1'b0, THRESH});

  always_ff @(posedge CLK) begin
    if (CLR || CNT_CLR) begin
      CNT <= '0;
      OVF <= 1'b0;
    end else if (evt) begin
      if (sat) OVF <= 1'b1;
      else     CNT <= CNT + W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EN) state_nxt = RUN;
      RUN: begin
        if (hit)      state_nxt = ALERT;
        else if (!EN) state_nxt = IDLE;
      end
      // A fresh hit outranks a simultaneous acknowledge.
      ALERT:   if (IRQ_ACK && !hit) state_nxt = EN ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  assign IRQ = (state == ALERT);

`ifdef TIMESTAMP_EN
  logic [TSW-1:0] ts;

  // LAST_TS takes the value ts reaches at the same edge, i.e. edges since CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      ts      <= '0;
      LAST_TS <= '0;
    end else begin
      ts <= ts + TSW'(1);
      if (evt) LAST_TS <= ts + TSW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_zero_run_event_monitor.sv
// tb/tb_zero_run_event_monitor.sv - directed self-checking bench for zero_run_event_monitor
module tb_zero_run_event_monitor;
  import zero_run_mon_pkg::*;

  logic       CLK;
  logic       CLR;
  logic       Y_IN;
  logic       EN;
  logic       CNT_CLR;
  logic [3:0] THRESH;
  logic       IRQ_ACK;
  logic [3:0] CNT;
  logic       OVF;
  logic       IRQ;
`ifdef TIMESTAMP_EN
  logic [15:0] LAST_TS;
`endif

  int tests = 0;
  int fails = 0;

  zero_run_event_monitor #(.W(4)) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .Y_IN    (Y_IN),
    .EN      (EN),
    .CNT_CLR (CNT_CLR),
    .THRESH  (THRESH),
    .IRQ_ACK (IRQ_ACK),
    .CNT     (CNT),
    .OVF     (OVF),
    .IRQ     (IRQ)
`ifdef TIMESTAMP_EN
    , .LAST_TS (LAST_TS)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    Y_IN = 1'b1;
    tick();
    Y_IN = 1'b0;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    CLR = 1'b1; Y_IN = 1'b0; EN = 1'b0; CNT_CLR = 1'b0; THRESH = 4'd0; IRQ_ACK = 1'b0;
    tick();
    tick();
    chk("reset_cnt", 32'(CNT), 32'd0);
    chk("reset_ovf", 32'(OVF), 32'd0);
    chk("reset_irq", 32'(IRQ), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    CLR = 1'b0;

    // basic count
    EN = 1'b1;
    tick();
    chk("idle_to_run", 32'(dut.state), 32'(RUN));
    pulse();
    pulse();
    pulse();
    chk("basic_cnt", 32'(CNT), 32'd3);
    chk("basic_irq", 32'(IRQ), 32'd0);
    chk("basic_ovf", 32'(OVF), 32'd0);

    // interrupt and acknowledge
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    chk("cntclr_cnt", 32'(CNT), 32'd0);
    THRESH = 4'd2;
    Y_IN = 1'b1;
    tick();
    chk("irq_first_cnt", 32'(CNT), 32'd1);
    chk("irq_first_irq", 32'(IRQ), 32'd0);
    Y_IN = 1'b0;
    tick();
    Y_IN = 1'b1;
    tick();
    chk("irq_second_cnt", 32'(CNT), 32'd2);
    chk("irq_second_irq", 32'(IRQ), 32'd1);
    Y_IN = 1'b0;
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    chk("ack_irq", 32'(IRQ), 32'd0);
    chk("ack_state", 32'(dut.state), 32'(RUN));

    // saturation
    THRESH = 4'd0;
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    for (int i = 0; i < 15; i++) pulse();
    chk("sat15_cnt", 32'(CNT), 32'd15);
    chk("sat15_ovf", 32'(OVF), 32'd0);
    pulse();
    chk("sat16_cnt", 32'(CNT), 32'd15);
    chk("sat16_ovf", 32'(OVF), 32'd1);
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    chk("satclr_cnt", 32'(CNT), 32'd0);
    chk("satclr_ovf", 32'(OVF), 32'd0);

    // CNT_CLR together with an event
    pulse();
    chk("pre_clr_cnt", 32'(CNT), 32'd1);
    Y_IN = 1'b1;
    CNT_CLR = 1'b1;
    tick();
    Y_IN = 1'b0;
    CNT_CLR = 1'b0;
    chk("clr_evt_cnt", 32'(CNT), 32'd0);
    tick();
    chk("clr_evt_cnt_after", 32'(CNT), 32'd0);

    // IRQ_ACK together with a hit in ALERT
    THRESH = 4'd1;
    Y_IN = 1'b1;
    tick();
    chk("t1_hit_irq", 32'(IRQ), 32'd1);
    Y_IN = 1'b0;
    tick();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    chk("alert_cntclr_irq", 32'(IRQ), 32'd1);
    Y_IN = 1'b1;
    IRQ_ACK = 1'b1;
    tick();
    Y_IN = 1'b0;
    IRQ_ACK = 1'b0;
    chk("ack_hit_irq", 32'(IRQ), 32'd1);
    chk("ack_hit_cnt", 32'(CNT), 32'd1);
    EN = 1'b0;
    tick();
    tick();
    chk("alert_en_low_irq", 32'(IRQ), 32'd1);
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    chk("ack_en_low_irq", 32'(IRQ), 32'd0);
    chk("ack_en_low_state", 32'(dut.state), 32'(IDLE));

    // enable gating and alternating flag
    THRESH = 4'd0;
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    Y_IN = 1'b1;
    tick();
    tick();
    EN = 1'b1;
    tick();
    tick();
    chk("en_high_y_cnt", 32'(CNT), 32'd0);
    for (int i = 0; i < 8; i++) begin
      Y_IN = (i % 2 == 1);
      tick();
    end
    chk("alt_cnt", 32'(CNT), 32'd4);
    Y_IN = 1'b0;
    tick();

`ifdef TIMESTAMP_EN
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    EN = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    Y_IN = 1'b1;
    tick();
    Y_IN = 1'b0;
    chk("ts_last", 32'(LAST_TS), 32'd10);
    chk("ts_cnt", 32'(CNT), 32'd1);
    tick();
`endif

    // CLR while in ALERT
    THRESH = 4'd2;
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    pulse();
    Y_IN = 1'b1;
    tick();
    Y_IN = 1'b0;
    chk("pre_clr_alert_irq", 32'(IRQ), 32'd1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_alert_irq", 32'(IRQ), 32'd0);
    chk("clr_alert_cnt", 32'(CNT), 32'd0);
    chk("clr_alert_state", 32'(dut.state), 32'(IDLE));
`ifdef TIMESTAMP_EN
    chk("clr_alert_ts", 32'(LAST_TS), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
